// File: rtl/wb_write_queue_pkg.sv
// Shared writeback types and defaults.
// Widths match the RegisterFile write port.
package wb_write_queue_pkg;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;
  localparam int REG_ZERO  = 0;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_write_queue_if.sv
// Writeback producer handshake (ALU and load paths).
// master: producer side; slave: queue side.
interface wb_write_queue_if
  import wb_write_queue_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
);

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready
  );

endinterface

// File: rtl/wb_fifo.sv
// Writeback entry storage: push/pop, count, per-entry valid.
// Ports: push_*, pop, head_*, full/empty/count, ent_* for bypass search.
module wb_fifo
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [ADDR_W-1:0]             push_rd,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [ADDR_W-1:0]             head_rd,
  output logic [DATA_W-1:0]             head_data,
  output logic                          full,
  output logic                          empty,
  output logic [CW-1:0]                 count,
  output logic [PW-1:0]                 head,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ent_rd,
  output logic [DEPTH-1:0][DATA_W-1:0]  ent_data
);

  logic [DEPTH-1:0][ADDR_W-1:0] rd_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0]             vld_q;
  logic [PW-1:0]                head_q;
  logic [PW-1:0]                tail_q;
  logic [CW-1:0]                cnt_q;
  logic                         push_ok;
  logic                         pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q   <= '0;
      data_q <= '0;
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) begin
        rd_q[tail_q]   <= push_rd;
        data_q[tail_q] <= push_data;
        vld_q[tail_q]  <= 1'b1;
        tail_q         <= tail_q + 1'b1;
      end
      if (pop_ok) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_rd   = rd_q[head_q];
  assign head_data = data_q[head_q];
  assign count     = cnt_q;
  assign head      = head_q;
  assign ent_valid = vld_q;
  assign ent_rd    = rd_q;
  assign ent_data  = data_q;

endmodule

// File: rtl/wb_write_queue.sv
// Register-file write queue: ALU/load arbitration, output register, bypass.
// Ports: src (producer handshake), wb_stall, reg_write/addrD/dataD, byp_*, count.
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  wb_write_queue_if.slave   src,
  input  logic              wb_stall,
  output logic              reg_write,
  output logic [ADDR_W-1:0] addrD,
  output logic [DATA_W-1:0] dataD,
  input  logic [ADDR_W-1:0] byp_addr,
  output logic              byp_hit,
  output logic [DATA_W-1:0] byp_data,
  output logic [CW-1:0]     count
);

  logic                         full;
  logic                         empty;
  logic                         mem_fire;
  logic                         alu_fire;
  logic                         push;
  logic                         pop;
  logic [ADDR_W-1:0]            push_rd;
  logic [DATA_W-1:0]            push_data;
  logic [ADDR_W-1:0]            head_rd;
  logic [DATA_W-1:0]            head_data;
  logic [PW-1:0]                head;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_rd;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [PW-1:0]                idx;

  // Loads win; the ALU only gets a slot when no load is offered.
  assign src.mem_ready = !full;
  assign src.alu_ready = !full && !src.mem_valid;
  assign mem_fire      = src.mem_valid && !full;
  assign alu_fire      = src.alu_valid && !full && !src.mem_valid;

  always_comb begin
    push_rd   = '0;
    push_data = '0;
    unique case (1'b1)
      mem_fire: begin
        push_rd   = src.mem_rd;
        push_data = src.mem_data;
      end
      alu_fire: begin
        push_rd   = src.alu_rd;
        push_data = src.alu_data;
      end
      default: ;
    endcase
  end

  // x0 writes are handshaken but silently discarded.
  assign push = (mem_fire || alu_fire)
             && (push_rd != ADDR_W'(REG_ZERO));
  assign pop  = !wb_stall && !empty;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_rd   (push_rd),
    .push_data (push_data),
    .pop       (pop),
    .head_rd   (head_rd),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd),
    .ent_data  (ent_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write <= 1'b0;
      addrD     <= '0;
      dataD     <= '0;
    end else if (pop) begin
      reg_write <= 1'b1;
      addrD     <= head_rd;
      dataD     <= head_data;
    end else begin
      reg_write <= 1'b0;
    end
  end

  // Scan oldest to newest so later matches override earlier ones.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    idx      = '0;
    if (byp_addr != ADDR_W'(REG_ZERO)) begin
      if (reg_write && (addrD == byp_addr)) begin
        byp_hit  = 1'b1;
        byp_data = dataD;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PW'(i);
        if (ent_valid[idx] && (ent_rd[idx] == byp_addr)) begin
          byp_hit  = 1'b1;
          byp_data = ent_data[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed vector bench for wb_write_queue.
// One row per cycle: inputs driven at negedge, outputs checked 1ns later.
module tb_wb_write_queue;
  import wb_write_queue_pkg::*;

  localparam int NV = 31;

  typedef struct {
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        st;
    logic [4:0]  ba;
    logic        e_mr;
    logic        e_ar;
    logic [2:0]  e_cnt;
    logic        e_rw;
    logic [4:0]  e_aD;
    logic [31:0] e_dD;
    logic        e_hit;
    logic [31:0] e_bd;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        wb_stall;
  logic        reg_write;
  logic [4:0]  addrD;
  logic [31:0] dataD;
  logic [4:0]  byp_addr;
  logic        byp_hit;
  logic [31:0] byp_data;
  logic [2:0]  count;

  int n_vec;
  int n_bad;
  vec_t vecs [NV];

  wb_write_queue_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  wb_write_queue #(
    .DEPTH  (4),
    .ADDR_W (5),
    .DATA_W (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .src       (bus),
    .wb_stall  (wb_stall),
    .reg_write (reg_write),
    .addrD     (addrD),
    .dataD     (dataD),
    .byp_addr  (byp_addr),
    .byp_hit   (byp_hit),
    .byp_data  (byp_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [79:0] act,
                     input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic mv, input logic [4:0] mrd, input logic [31:0] md,
    input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic st, input logic [4:0] ba,
    input logic mr, input logic ar, input logic [2:0] cnt,
    input logic rw, input logic [4:0] aD, input logic [31:0] dD,
    input logic hit, input logic [31:0] bd);
    vec_t v;
    v.mv = mv; v.mrd = mrd; v.md = md;
    v.av = av; v.ard = ard; v.ad = ad;
    v.st = st; v.ba = ba;
    v.e_mr = mr; v.e_ar = ar; v.e_cnt = cnt;
    v.e_rw = rw; v.e_aD = aD; v.e_dD = dD;
    v.e_hit = hit; v.e_bd = bd;
    return v;
  endfunction

  task automatic drive(input logic mv, input logic [4:0] mrd,
                       input logic [31:0] md, input logic av,
                       input logic [4:0] ard, input logic [31:0] ad,
                       input logic st, input logic [4:0] ba);
    bus.mem_valid = mv;
    bus.mem_rd    = mrd;
    bus.mem_data  = md;
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    wb_stall      = st;
    byp_addr      = ba;
  endtask

  localparam logic [31:0] D12 = 32'h11111112;
  localparam logic [31:0] D13 = 32'h11111113;
  localparam logic [31:0] D14 = 32'h11111114;
  localparam logic [31:0] D15 = 32'h11111115;
  localparam logic [31:0] D16 = 32'h11111116;
  localparam logic [31:0] A3  = 32'hAAAA0003;
  localparam logic [31:0] B4  = 32'hBBBB0004;
  localparam logic [31:0] N9  = 32'h00000099;
  localparam logic [31:0] DB  = 32'hDEADBEEF;

  wb_entry_t pre [3];

  initial begin
    n_vec = 0;
    n_bad = 0;
    // idle after reset
    vecs[0]  = mk(0,0,0,   0,0,0,   0,0, 1,1,0,0,0,0,   0,0);
    // single ALU write
    vecs[1]  = mk(0,0,0,   1,5,D16, 0,5, 1,1,0,0,0,0,   0,0);
    vecs[2]  = mk(0,0,0,   0,0,0,   0,5, 1,1,1,0,0,0,   1,D16);
    vecs[3]  = mk(0,0,0,   0,0,0,   0,5, 1,1,0,1,5,D16, 1,D16);
    vecs[4]  = mk(0,0,0,   0,0,0,   0,5, 1,1,0,0,5,D16, 0,0);
    // load priority
    vecs[5]  = mk(1,4,B4,  1,3,A3,  0,4, 1,0,0,0,5,D16, 0,0);
    vecs[6]  = mk(0,0,0,   1,3,A3,  0,4, 1,1,1,0,5,D16, 1,B4);
    vecs[7]  = mk(0,0,0,   0,0,0,   0,3, 1,1,1,1,4,B4,  1,A3);
    vecs[8]  = mk(0,0,0,   0,0,0,   0,4, 1,1,0,1,3,A3,  0,0);
    // stall until full, then drain
    vecs[9]  = mk(0,0,0,   1,1,D12, 1,0, 1,1,0,0,3,A3,  0,0);
    vecs[10] = mk(0,0,0,   1,2,D13, 1,0, 1,1,1,0,3,A3,  0,0);
    vecs[11] = mk(0,0,0,   1,3,D14, 1,0, 1,1,2,0,3,A3,  0,0);
    vecs[12] = mk(0,0,0,   1,4,D15, 1,0, 1,1,3,0,3,A3,  0,0);
    vecs[13] = mk(0,0,0,   1,9,N9,  1,0, 0,0,4,0,3,A3,  0,0);
    vecs[14] = mk(0,0,0,   1,9,N9,  0,2, 0,0,4,0,3,A3,  1,D13);
    vecs[15] = mk(0,0,0,   1,9,N9,  0,9, 1,1,3,1,1,D12, 0,0);
    vecs[16] = mk(0,0,0,   0,0,0,   0,9, 1,1,3,1,2,D13, 1,N9);
    vecs[17] = mk(0,0,0,   0,0,0,   0,0, 1,1,2,1,3,D14, 0,0);
    vecs[18] = mk(0,0,0,   0,0,0,   0,0, 1,1,1,1,4,D15, 0,0);
    vecs[19] = mk(0,0,0,   0,0,0,   0,9, 1,1,0,1,9,N9,  1,N9);
    vecs[20] = mk(0,0,0,   0,0,0,   0,0, 1,1,0,0,9,N9,  0,0);
    // x0 drop
    vecs[21] = mk(1,0,DB,  0,0,0,   0,0, 1,0,0,0,9,N9,  0,0);
    vecs[22] = mk(0,0,0,   0,0,0,   0,0, 1,1,0,0,9,N9,  0,0);
    vecs[23] = mk(0,0,0,   0,0,0,   0,9, 1,1,0,0,9,N9,  0,0);
    // bypass newest wins
    vecs[24] = mk(1,7,1,   0,0,0,   1,7, 1,0,0,0,9,N9,  0,0);
    vecs[25] = mk(1,7,2,   0,0,0,   1,7, 1,0,1,0,9,N9,  1,1);
    vecs[26] = mk(0,0,0,   0,0,0,   1,7, 1,1,2,0,9,N9,  1,2);
    vecs[27] = mk(0,0,0,   0,0,0,   0,7, 1,1,2,0,9,N9,  1,2);
    vecs[28] = mk(0,0,0,   0,0,0,   0,7, 1,1,1,1,7,1,   1,2);
    vecs[29] = mk(0,0,0,   0,0,0,   0,7, 1,1,0,1,7,2,   1,2);
    vecs[30] = mk(0,0,0,   0,0,0,   0,7, 1,1,0,0,7,2,   0,0);

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].mv, vecs[i].mrd, vecs[i].md,
            vecs[i].av, vecs[i].ard, vecs[i].ad,
            vecs[i].st, vecs[i].ba);
      #1;
      chk($sformatf("vec%0d", i),
          {4'h0, bus.mem_ready, bus.alu_ready, count,
           reg_write, addrD, dataD, byp_hit, byp_data},
          {4'h0, vecs[i].e_mr, vecs[i].e_ar, vecs[i].e_cnt,
           vecs[i].e_rw, vecs[i].e_aD, vecs[i].e_dD,
           vecs[i].e_hit, vecs[i].e_bd});
    end

    // reset with three entries in flight
    pre[0] = '{rd: 5'd10, data: 32'hC0DE000A};
    pre[1] = '{rd: 5'd11, data: 32'hC0DE000B};
    pre[2] = '{rd: 5'd12, data: 32'hC0DE000C};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 1, pre[i].rd, pre[i].data, 1, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 5'd11);
    #1;
    chk("preload", {77'd0, count}, 80'd3);
    reset = 1'b0;
    #1;
    chk("async_clear",
        {42'd0, count, reg_write, addrD, dataD},
        80'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    wb_stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_reset%0d", i),
          {9'd0, count, reg_write, addrD, dataD,
           byp_hit, byp_data},
          80'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Initiator side of the register-file write port: collects writeback results from the ALU and load paths, buffers them, and drives reg_write/addrD/dataD one entry per cycle.
- Provides a combinational bypass lookup so read stages see the newest in-flight value for a register before the register file commits it.
- Sits between the execute/memory stages and the RegisterFile write port.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result offered.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU result accepted this cycle.
- mem_valid  in  1  load result offered.
- mem_rd  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load result.
- mem_ready  out  1  load result accepted this cycle.
- wb_stall  in  1  hold the write port idle; no dequeue.
- reg_write  out  1  write enable to the register file (registered).
- addrD  out  ADDR_W  write address (registered).
- dataD  out  DATA_W  write data (registered).
- byp_addr  in  ADDR_W  bypass lookup address.
- byp_hit  out  1  a pending write to byp_addr exists.
- byp_data  out  DATA_W  newest pending value for byp_addr.
- count  out  clog2(DEPTH+1)  current queue occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - Queue emptied; count=0.
  - reg_write=0, addrD=0, dataD=0.
  - Pointers cleared. Any in-flight entries are discarded, not written.
- Acceptance (combinational ready, based on pre-edge state):
  - mem_ready = !full.
  - alu_ready = !full && !mem_valid. The load path has fixed priority.
  - At most one enqueue per cycle. A transfer occurs when valid && ready.
- Destination register 0:
  - A transfer with rd=0 is accepted (ready behaves as normal) but not stored.
  - count is unchanged and no write is ever issued for it.
- Dequeue on each rising edge:
  - If !wb_stall && !empty (pre-edge): the head is popped and loaded into addrD/dataD, and reg_write=1.
  - Otherwise reg_write=0. addrD/dataD hold their previous values.
- Latency and ordering:
  - A result accepted at edge N is driven on the port after edge N+1 and captured by the register file at edge N+2, provided no stall and nothing older is ahead of it.
  - Entries leave in FIFO order.
- Simultaneous push and pop in one edge: both happen; count is unchanged.
  - When full, no push is possible that cycle (ready is low) even if a pop occurs. Ready reasserts the cycle after the pop.
- Wrap-around: pointers are clog2(DEPTH) bits and wrap naturally. full = (count==DEPTH); empty = (count==0).
- Bypass (combinational):
  - Candidates are the valid queue entries plus the output stage (reg_write=1 entry).
  - Among candidates whose address equals byp_addr, the newest wins. Queue tail is newest, output stage is oldest.
  - byp_hit=0 and byp_data=0 when there is no match or byp_addr=0.
  - Same-cycle enqueue data is not visible until after the edge.
- wb_stall is sampled at the edge. Asserting it never drops or reorders entries.

Decomposition:
- Shared package holds:
  - ADDR_W and DATA_W defaults shared with RegisterFile.
  - A writeback entry record {rd, data}.
  - The constant REG_ZERO = 0.
- Natural sub-module: wb_fifo (storage, pointers, count, per-entry valid).
- Arbitration, output register and bypass search live in the top.

Test Plan:
- Reset check: hold reset=0 for 2 edges with queue holding 3 entries, then release → count=0, reg_write=0, addrD=0, dataD=0; the 3 entries are never written.
- Single ALU write: alu rd=5, data=0x11111116 at edge N → reg_write=1, addrD=5, dataD=0x11111116 after N+1; reg_write=0 after N+2.
- Priority: alu (rd=3, 0xAAAA0003) and mem (rd=4, 0xBBBB0004) valid in the same cycle → mem_ready=1, alu_ready=0. Mem written first; alu accepted next cycle and written one cycle later.
- Stall and full: wb_stall=1 while pushing rd=1..4 (0x11111112..0x11111115) → count=4, both readies 0. Release stall → four writes in order rd=1,2,3,4 on consecutive cycles; ready reasserts after the first pop.
- R0 drop: mem rd=0, data=0xDEADBEEF → mem_ready=1, count stays 0, no reg_write; bypass on byp_addr=0 gives hit=0, data=0.
- Bypass newest-wins: stall, push rd=7 values 0x1 then 0x2 → byp_addr=7 gives hit=1, data=0x2. After both drain, hit=0.
